// File: rtl/oc8051_su_gate.sv
// Supervisor call gate for the oc8051: tracks call/interrupt nesting with a flag stack
// and pulses privilege changes. Optional macro OC8051_SU_IRQ_GATE_EN makes irq entry a gate.
module oc8051_su_gate #(
   parameter logic [15:0] SU_BASE    = 16'hF000,
   parameter logic [15:0] SU_LIMIT   = 16'hFFFF,
   parameter logic [15:0] ENTRY_SPAN = 16'h0040,
   parameter int          STK_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        su_en,
   input  logic        priv_lvl,
   input  logic        op_valid,
   input  logic        op_call,
   input  logic        op_ret,
   input  logic [15:0] target_pc,
   input  logic        irq_ack,
   input  logic        fault_clr,
   output logic        enter_su_mode,
   output logic        leave_su_mode,
   output logic        su_fault,
   output logic [1:0]  fault_cause,
   output logic [15:0] fault_pc
);

   localparam int          PW       = $clog2(STK_DEPTH);
   localparam logic [PW:0] FULL_PTR = (PW+1)'(STK_DEPTH);
   localparam logic [PW:0] ONE_PTR  = (PW+1)'(1);
   localparam logic [PW:0] ZERO_PTR = (PW+1)'(0);
   localparam logic [16:0] GATE_END = {1'b0, SU_BASE} + {1'b0, ENTRY_SPAN} - 17'd1;

   localparam logic [1:0] CAUSE_PRIV = 2'b01;
   localparam logic [1:0] CAUSE_OVF  = 2'b10;
   localparam logic [1:0] CAUSE_COLL = 2'b11;

`ifdef OC8051_SU_IRQ_GATE_EN
   localparam logic IRQ_FLAG = 1'b1;
`else
   localparam logic IRQ_FLAG = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ENTER = 2'b01,
      LEAVE = 2'b10,
      FAULT = 2'b11
   } state_t;

   state_t               state_r;
   state_t               ev_state_s;
   state_t               state_nxt_s;
   logic [STK_DEPTH-1:0] stk_r;
   logic [PW:0]          ptr_r;
   logic [PW:0]          ptr_nxt_s;
   logic [PW:0]          top_s;
   logic [PW-1:0]        wr_idx_s;
   logic [PW-1:0]        rd_idx_s;
   logic                 is_gate_s;
   logic                 is_prot_s;
   logic                 is_call_s;
   logic                 is_ret_s;
   logic                 full_s;
   logic                 empty_s;
   logic                 ev_push_s;
   logic                 ev_flag_s;
   logic [PW:0]          ev_ptr_s;
   logic [1:0]           ev_cause_s;
   logic [15:0]          ev_pc_s;
   logic                 push_s;
   logic [1:0]           cause_nxt_s;
   logic [15:0]          fpc_nxt_s;

   // Address classification and stack bookkeeping
   always_comb begin
      is_gate_s = (target_pc >= SU_BASE) && ({1'b0, target_pc} <= GATE_END) &&
                  (target_pc[2:0] == 3'b000);
      is_prot_s = (target_pc >= SU_BASE) && (target_pc <= SU_LIMIT);
      is_call_s = op_valid & op_call & ~op_ret;
      is_ret_s  = op_valid & op_ret & ~op_call;
      full_s    = (ptr_r == FULL_PTR);
      empty_s   = (ptr_r == ZERO_PTR);
      top_s     = ptr_r - ONE_PTR;
      wr_idx_s  = ptr_r[PW-1:0];
      rd_idx_s  = top_s[PW-1:0];
   end

   // Decode of one incoming event, shared by IDLE, ENTER and LEAVE
   always_comb begin
      ev_state_s = IDLE;
      ev_push_s  = 1'b0;
      ev_flag_s  = 1'b0;
      ev_ptr_s   = ptr_r;
      ev_cause_s = fault_cause;
      ev_pc_s    = fault_pc;
      if (op_valid && irq_ack) begin
         ev_state_s = FAULT;
         ev_cause_s = CAUSE_COLL;
         ev_pc_s    = target_pc;
      end else if (irq_ack) begin
         if (full_s) begin
            ev_state_s = FAULT;
            ev_cause_s = CAUSE_OVF;
            ev_pc_s    = 16'h0000;
         end else begin
            ev_push_s  = 1'b1;
            ev_flag_s  = IRQ_FLAG;
            ev_ptr_s   = ptr_r + ONE_PTR;
            ev_state_s = IRQ_FLAG ? ENTER : IDLE;
         end
      end else if (is_call_s) begin
         // Privilege violation outranks overflow: the call is rejected either way
         if (!priv_lvl && is_prot_s && !is_gate_s) begin
            ev_state_s = FAULT;
            ev_cause_s = CAUSE_PRIV;
            ev_pc_s    = target_pc;
         end else if (full_s) begin
            ev_state_s = FAULT;
            ev_cause_s = CAUSE_OVF;
            ev_pc_s    = target_pc;
         end else begin
            ev_push_s  = 1'b1;
            ev_flag_s  = is_gate_s;
            ev_ptr_s   = ptr_r + ONE_PTR;
            ev_state_s = is_gate_s ? ENTER : IDLE;
         end
      end else if (is_ret_s) begin
         if (empty_s) begin
            ev_state_s = IDLE;
         end else begin
            ev_ptr_s   = top_s;
            ev_state_s = stk_r[rd_idx_s] ? LEAVE : IDLE;
         end
      end else begin
         ev_state_s = IDLE;
      end
   end

   // Next-state selection; FAULT freezes everything until cleared
   always_comb begin
      state_nxt_s = IDLE;
      ptr_nxt_s   = ptr_r;
      push_s      = 1'b0;
      cause_nxt_s = fault_cause;
      fpc_nxt_s   = fault_pc;
      case (state_r)
         IDLE, ENTER, LEAVE: begin
            state_nxt_s = ev_state_s;
            ptr_nxt_s   = ev_ptr_s;
            push_s      = ev_push_s;
            cause_nxt_s = ev_cause_s;
            fpc_nxt_s   = ev_pc_s;
         end
         FAULT: begin
            if (fault_clr) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = FAULT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Control FSM with registered pulse and fault outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= IDLE;
         ptr_r         <= ZERO_PTR;
         enter_su_mode <= 1'b0;
         leave_su_mode <= 1'b0;
         su_fault      <= 1'b0;
         fault_cause   <= 2'b00;
         fault_pc      <= 16'h0000;
      end else if (!su_en) begin
         state_r       <= IDLE;
         ptr_r         <= ZERO_PTR;
         enter_su_mode <= 1'b0;
         leave_su_mode <= 1'b0;
         su_fault      <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         ptr_r         <= ptr_nxt_s;
         enter_su_mode <= (state_nxt_s == ENTER);
         leave_su_mode <= (state_nxt_s == LEAVE);
         su_fault      <= (state_nxt_s == FAULT);
         fault_cause   <= cause_nxt_s;
         fault_pc      <= fpc_nxt_s;
      end
   end

   // Gate-flag stack storage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stk_r <= {STK_DEPTH{1'b0}};
      end else if (su_en && push_s) begin
         stk_r[wr_idx_s] <= ev_flag_s;
      end else begin
         stk_r <= stk_r;
      end
   end

endmodule

// File: tb/tb_oc8051_su_gate.sv
// Directed self-checking bench for oc8051_su_gate (default parameters).
module tb_oc8051_su_gate;

   logic        clk = 1'b0;
   logic        rst;
   logic        su_en;
   logic        priv_lvl;
   logic        op_valid;
   logic        op_call;
   logic        op_ret;
   logic [15:0] target_pc;
   logic        irq_ack;
   logic        fault_clr;
   logic        enter_su_mode;
   logic        leave_su_mode;
   logic        su_fault;
   logic [1:0]  fault_cause;
   logic [15:0] fault_pc;
   logic [4:0]  flags;

   int checks = 0;
   int errors = 0;

`ifdef OC8051_SU_IRQ_GATE_EN
   localparam logic IRQ_EXP = 1'b1;
`else
   localparam logic IRQ_EXP = 1'b0;
`endif

   oc8051_su_gate dut (
      .clk(clk), .rst(rst), .su_en(su_en), .priv_lvl(priv_lvl),
      .op_valid(op_valid), .op_call(op_call), .op_ret(op_ret),
      .target_pc(target_pc), .irq_ack(irq_ack), .fault_clr(fault_clr),
      .enter_su_mode(enter_su_mode), .leave_su_mode(leave_su_mode),
      .su_fault(su_fault), .fault_cause(fault_cause), .fault_pc(fault_pc)
   );

   always #5 clk = ~clk;

   // {enter, leave, su_fault, fault_cause}
   assign flags = {enter_su_mode, leave_su_mode, su_fault, fault_cause};

   task step();
      @(posedge clk);
      #1;
   endtask

   task clear_in();
      op_valid  = 1'b0;
      op_call   = 1'b0;
      op_ret    = 1'b0;
      irq_ack   = 1'b0;
      fault_clr = 1'b0;
   endtask

   task do_call(input logic [15:0] a);
      op_valid  = 1'b1;
      op_call   = 1'b1;
      target_pc = a;
      step();
      clear_in();
   endtask

   task do_ret();
      op_valid = 1'b1;
      op_ret   = 1'b1;
      step();
      clear_in();
   endtask

   task do_clr();
      fault_clr = 1'b1;
      step();
      clear_in();
   endtask

   task test_reset();
      step();
      step();
      checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL reset_flags: got %b want %b", flags, 5'b00000); end
      checks++; if (fault_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want %h", fault_pc, 16'h0000); end
      checks++; if (dut.ptr_r !== 4'd0) begin errors++; $display("FAIL reset_ptr: got %0d want %0d", dut.ptr_r, 0); end
      rst = 1'b1;
      step();
   endtask

   task test_gate_call();
      priv_lvl = 1'b0;
      do_call(16'hF008);
      checks++; if (flags !== 5'b10000) begin errors++; $display("FAIL gate_enter: got %b want %b", flags, 5'b10000); end
      checks++; if (dut.ptr_r !== 4'd1) begin errors++; $display("FAIL gate_ptr: got %0d want %0d", dut.ptr_r, 1); end
      step();
      checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL gate_pulse_end: got %b want %b", flags, 5'b00000); end
      do_ret();
      checks++; if (flags !== 5'b01000) begin errors++; $display("FAIL gate_leave: got %b want %b", flags, 5'b01000); end
      checks++; if (dut.ptr_r !== 4'd0) begin errors++; $display("FAIL gate_ret_ptr: got %0d want %0d", dut.ptr_r, 0); end
      step();
      checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL gate_leave_end: got %b want %b", flags, 5'b00000); end
   endtask

   task test_priv_fault();
      priv_lvl = 1'b0;
      do_call(16'hF100);
      checks++; if (flags !== 5'b00101) begin errors++; $display("FAIL priv_fault: got %b want %b", flags, 5'b00101); end
      checks++; if (fault_pc !== 16'hF100) begin errors++; $display("FAIL priv_pc: got %h want %h", fault_pc, 16'hF100); end
      checks++; if (dut.ptr_r !== 4'd0) begin errors++; $display("FAIL priv_ptr: got %0d want %0d", dut.ptr_r, 0); end
      do_call(16'hF008);
      checks++; if (flags !== 5'b00101) begin errors++; $display("FAIL fault_ignore: got %b want %b", flags, 5'b00101); end
      checks++; if (dut.ptr_r !== 4'd0) begin errors++; $display("FAIL fault_frozen_ptr: got %0d want %0d", dut.ptr_r, 0); end
      do_clr();
      checks++; if (flags !== 5'b00001) begin errors++; $display("FAIL fault_clr: got %b want %b", flags, 5'b00001); end
      checks++; if (fault_pc !== 16'hF100) begin errors++; $display("FAIL fault_pc_hold: got %h want %h", fault_pc, 16'hF100); end
      do_call(16'hF008);
      checks++; if (flags !== 5'b10001) begin errors++; $display("FAIL post_clr_enter: got %b want %b", flags, 5'b10001); end
      do_ret();
      checks++; if (flags !== 5'b01001) begin errors++; $display("FAIL post_clr_leave: got %b want %b", flags, 5'b01001); end
   endtask

   task test_nested();
      priv_lvl = 1'b0;
      do_call(16'hF000);
      checks++; if (flags !== 5'b10001) begin errors++; $display("FAIL nest_enter: got %b want %b", flags, 5'b10001); end
      priv_lvl = 1'b1;
      do_call(16'hF200);
      checks++; if (flags !== 5'b00001) begin errors++; $display("FAIL nest_inner: got %b want %b", flags, 5'b00001); end
      do_call(16'hF004);
      checks++; if (flags !== 5'b00001) begin errors++; $display("FAIL nest_misaligned: got %b want %b", flags, 5'b00001); end
      checks++; if (dut.ptr_r !== 4'd3) begin errors++; $display("FAIL nest_ptr: got %0d want %0d", dut.ptr_r, 3); end
      do_ret();
      checks++; if (flags !== 5'b00001) begin errors++; $display("FAIL nest_ret1: got %b want %b", flags, 5'b00001); end
      do_ret();
      checks++; if (flags !== 5'b00001) begin errors++; $display("FAIL nest_ret2: got %b want %b", flags, 5'b00001); end
      do_ret();
      checks++; if (flags !== 5'b01001) begin errors++; $display("FAIL nest_ret3: got %b want %b", flags, 5'b01001); end
      do_ret();
      checks++; if (flags !== 5'b00001) begin errors++; $display("FAIL empty_ret: got %b want %b", flags, 5'b00001); end
      checks++; if (dut.ptr_r !== 4'd0) begin errors++; $display("FAIL empty_ret_ptr: got %0d want %0d", dut.ptr_r, 0); end
      priv_lvl = 1'b0;
      do_call(16'hF038);
      checks++; if (flags !== 5'b10001) begin errors++; $display("FAIL last_gate: got %b want %b", flags, 5'b10001); end
      do_ret();
      do_call(16'hF040);
      checks++; if (flags !== 5'b00101) begin errors++; $display("FAIL past_gate_area: got %b want %b", flags, 5'b00101); end
      checks++; if (fault_pc !== 16'hF040) begin errors++; $display("FAIL past_gate_pc: got %h want %h", fault_pc, 16'hF040); end
      do_clr();
   endtask

   task test_overflow();
      priv_lvl = 1'b0;
      for (int i = 0; i < 8; i++) begin
         do_call(16'h1000);
         checks++; if (flags !== 5'b00001) begin errors++; $display("FAIL fill_%0d: got %b want %b", i, flags, 5'b00001); end
      end
      checks++; if (dut.ptr_r !== 4'd8) begin errors++; $display("FAIL full_ptr: got %0d want %0d", dut.ptr_r, 8); end
      do_call(16'h1000);
      checks++; if (flags !== 5'b00110) begin errors++; $display("FAIL ovf_fault: got %b want %b", flags, 5'b00110); end
      checks++; if (fault_pc !== 16'h1000) begin errors++; $display("FAIL ovf_pc: got %h want %h", fault_pc, 16'h1000); end
      checks++; if (dut.ptr_r !== 4'd8) begin errors++; $display("FAIL ovf_ptr: got %0d want %0d", dut.ptr_r, 8); end
      do_clr();
      irq_ack = 1'b1;
      step();
      clear_in();
      checks++; if (flags !== 5'b00110) begin errors++; $display("FAIL irq_ovf: got %b want %b", flags, 5'b00110); end
      checks++; if (fault_pc !== 16'h0000) begin errors++; $display("FAIL irq_ovf_pc: got %h want %h", fault_pc, 16'h0000); end
      do_clr();
      su_en = 1'b0;
      step();
      checks++; if (dut.ptr_r !== 4'd0) begin errors++; $display("FAIL disable_ptr: got %0d want %0d", dut.ptr_r, 0); end
      do_call(16'hF008);
      checks++; if (flags !== 5'b00010) begin errors++; $display("FAIL disabled_call: got %b want %b", flags, 5'b00010); end
      checks++; if (dut.ptr_r !== 4'd0) begin errors++; $display("FAIL disabled_ptr: got %0d want %0d", dut.ptr_r, 0); end
      su_en = 1'b1;
      step();
   endtask

   task test_irq();
      irq_ack = 1'b1;
      step();
      clear_in();
      checks++; if (flags !== {IRQ_EXP, 4'b0010}) begin errors++; $display("FAIL irq_entry: got %b want %b", flags, {IRQ_EXP, 4'b0010}); end
      checks++; if (dut.ptr_r !== 4'd1) begin errors++; $display("FAIL irq_ptr: got %0d want %0d", dut.ptr_r, 1); end
      do_ret();
      checks++; if (flags !== {1'b0, IRQ_EXP, 3'b010}) begin errors++; $display("FAIL reti: got %b want %b", flags, {1'b0, IRQ_EXP, 3'b010}); end
      op_valid  = 1'b1;
      op_call   = 1'b1;
      target_pc = 16'h1234;
      irq_ack   = 1'b1;
      step();
      clear_in();
      checks++; if (flags !== 5'b00111) begin errors++; $display("FAIL collide: got %b want %b", flags, 5'b00111); end
      checks++; if (fault_pc !== 16'h1234) begin errors++; $display("FAIL collide_pc: got %h want %h", fault_pc, 16'h1234); end
      checks++; if (dut.ptr_r !== 4'd0) begin errors++; $display("FAIL collide_ptr: got %0d want %0d", dut.ptr_r, 0); end
      do_clr();
   endtask

   task test_back_to_back();
      priv_lvl = 1'b0;
      op_valid  = 1'b1;
      op_call   = 1'b1;
      target_pc = 16'hF008;
      step();
      checks++; if (flags !== 5'b10011) begin errors++; $display("FAIL b2b_enter1: got %b want %b", flags, 5'b10011); end
      target_pc = 16'hF010;
      step();
      clear_in();
      checks++; if (flags !== 5'b10011) begin errors++; $display("FAIL b2b_enter2: got %b want %b", flags, 5'b10011); end
      checks++; if (dut.ptr_r !== 4'd2) begin errors++; $display("FAIL b2b_ptr: got %0d want %0d", dut.ptr_r, 2); end
      do_ret();
      checks++; if (flags !== 5'b01011) begin errors++; $display("FAIL b2b_leave1: got %b want %b", flags, 5'b01011); end
      do_ret();
      checks++; if (flags !== 5'b01011) begin errors++; $display("FAIL b2b_leave2: got %b want %b", flags, 5'b01011); end
      op_valid  = 1'b1;
      op_call   = 1'b1;
      op_ret    = 1'b1;
      target_pc = 16'hF008;
      step();
      clear_in();
      checks++; if (flags !== 5'b00011) begin errors++; $display("FAIL both_ignored: got %b want %b", flags, 5'b00011); end
      op_valid = 1'b1;
      step();
      clear_in();
      checks++; if (dut.ptr_r !== 4'd0) begin errors++; $display("FAIL none_ignored: got %0d want %0d", dut.ptr_r, 0); end
   endtask

   task test_reset_mid_pulse();
      priv_lvl = 1'b0;
      do_call(16'hF008);
      checks++; if (flags !== 5'b10011) begin errors++; $display("FAIL pre_rst_enter: got %b want %b", flags, 5'b10011); end
      rst = 1'b0;
      #1;
      checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL rst_truncate: got %b want %b", flags, 5'b00000); end
      checks++; if (fault_pc !== 16'h0000) begin errors++; $display("FAIL rst_pc: got %h want %h", fault_pc, 16'h0000); end
      checks++; if (dut.ptr_r !== 4'd0) begin errors++; $display("FAIL rst_ptr: got %0d want %0d", dut.ptr_r, 0); end
      step();
      rst = 1'b1;
      step();
      do_ret();
      checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL rst_empty_ret: got %b want %b", flags, 5'b00000); end
      do_call(16'hF008);
      checks++; if (flags !== 5'b10000) begin errors++; $display("FAIL rst_then_enter: got %b want %b", flags, 5'b10000); end
      checks++; if (dut.ptr_r !== 4'd1) begin errors++; $display("FAIL rst_then_ptr: got %0d want %0d", dut.ptr_r, 1); end
      do_ret();
      checks++; if (flags !== 5'b01000) begin errors++; $display("FAIL rst_then_leave: got %b want %b", flags, 5'b01000); end
   endtask

   initial begin
      rst       = 1'b0;
      su_en     = 1'b1;
      priv_lvl  = 1'b0;
      target_pc = 16'h0000;
      clear_in();
      test_reset();
      test_gate_call();
      test_priv_fault();
      test_nested();
      test_overflow();
      test_irq();
      test_back_to_back();
      test_reset_mid_pulse();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/oc8051_su_gate.md
OC8051_SU_GATE -- requirements
Module: oc8051_su_gate

Interface
REQ-001 Parameter SU_BASE, default 16'hF000, first address of the supervisor code region.
REQ-002 Parameter SU_LIMIT, default 16'hFFFF, last address of the supervisor code region (inclusive).
REQ-003 Parameter ENTRY_SPAN, default 16'h0040, byte size of the gate area starting at SU_BASE.
REQ-004 Parameter STK_DEPTH, default 8, depth of the gate-flag stack (power of two, 2..32).
REQ-005 Ports: clk in 1 system clock; rst in 1 asynchronous active-low reset (one clock, reset asynchronous and active-low).
REQ-006 Ports: su_en in 1 supervisor feature enable; priv_lvl in 1 current privilege level from the privilege counter.
REQ-007 Ports: op_valid in 1 one-cycle decode strobe; op_call in 1 strobed op is ACALL/LCALL; op_ret in 1 strobed op is RET/RETI.
REQ-008 Ports: target_pc in 16 call destination, valid with op_valid; irq_ack in 1 one-cycle interrupt vector entry strobe; fault_clr in 1 clears fault.
REQ-009 Ports: enter_su_mode out 1 and leave_su_mode out 1 one-cycle pulses to the privilege counter; su_fault out 1 sticky; fault_cause out 2; fault_pc out 16.

Function
REQ-010 Gate address = target_pc in [SU_BASE, SU_BASE+ENTRY_SPAN-1] with target_pc[2:0]==3'b000; protected address = target_pc in [SU_BASE, SU_LIMIT].
REQ-011 Block SHALL hold a STK_DEPTH-entry 1-bit stack plus pointer 0..STK_DEPTH; each call/interrupt pushes a flag, each return pops one.
REQ-012 Call to a gate address pushes flag 1 and pulses enter_su_mode in the next cycle (latency 1).
REQ-013 Call to any other address pushes flag 0, no pulse, unless REQ-015 applies.
REQ-014 Return pops; popped flag 1 pulses leave_su_mode in the next cycle; popped 0, no pulse; return on empty stack ignored (no pop, no pulse, no fault).
REQ-015 Call with priv_lvl==0 to a protected non-gate address: no push, no pulse, enter FAULT, fault_cause=2'b01, fault_pc=target_pc.
REQ-016 Push with pointer==STK_DEPTH: no push, no pulse, FAULT, fault_cause=2'b10, fault_pc=target_pc (16'h0000 for irq_ack).
REQ-017 op_valid and irq_ack in the same cycle: neither processed, FAULT, fault_cause=2'b11, fault_pc=target_pc.
REQ-018 op_valid with neither op_call nor op_ret, or with both, SHALL be ignored.
REQ-019 FSM states IDLE, ENTER, LEAVE, FAULT; ENTER/LEAVE last exactly one cycle and drive the matching pulse; otherwise pulses low.
REQ-020 IDLE/ENTER/LEAVE evaluate a new event identically (back-to-back events legal) and go to ENTER, LEAVE, FAULT, or IDLE.
REQ-021 FAULT: all events ignored, stack frozen, su_fault=1; fault_clr for one cycle returns to IDLE; fault_cause/fault_pc hold until the next fault.
REQ-022 enter_su_mode and leave_su_mode SHALL never be high in the same cycle.
REQ-023 su_en==0: stack pointer forced to 0, FSM forced to IDLE, pulses and su_fault low, events ignored; su_en rising resumes from empty stack.

Reset
REQ-024 rst low asynchronously: FSM=IDLE, pointer=0, stack entries 0, enter_su_mode=0, leave_su_mode=0, su_fault=0, fault_cause=2'b00, fault_pc=16'h0000.
REQ-025 rst low mid-pulse truncates the pulse immediately; state is lost; first event after rst high is processed on an empty stack.

Configuration
REQ-026 Macro OC8051_SU_IRQ_GATE_EN defined: irq_ack pushes flag 1 and pulses enter_su_mode (interrupts run in supervisor mode, RETI leaves).
REQ-027 Macro OC8051_SU_IRQ_GATE_EN undefined: irq_ack pushes flag 0 and never pulses; all other behaviour unchanged.

Verification
REQ-028 su_en=1, priv_lvl=0, call target_pc=16'hF008 -> enter_su_mode high exactly one cycle later, pointer=1; then op_ret -> leave_su_mode one cycle pulse, pointer=0.
REQ-029 priv_lvl=0, call 16'hF100 -> no pulse, su_fault=1, fault_cause=01, fault_pc=16'hF100; fault_clr -> su_fault=0, FSM IDLE.
REQ-030 Gate call 16'hF000, inner call 16'hF200 (priv_lvl=1), two rets -> exactly one enter pulse, one leave pulse on the second ret.
REQ-031 Nine consecutive calls to 16'h1000 (STK_DEPTH=8) -> ninth sets fault_cause=10, fault_pc=16'h1000, pointer stays 8.
REQ-032 irq_ack with macro defined -> enter_su_mode pulse; undefined -> none; irq_ack with op_valid -> fault_cause=11.
REQ-033 rst low during ENTER -> enter_su_mode low in the same cycle, all outputs at REQ-024 values; su_en=0 with gate call -> no pulse.
